traffic_ctrl: RTL and testbench

TRAFFIC_CTRL -- requirements
Module: traffic_ctrl

---
 rtl/traffic_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_traffic_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_ctrl.sv
// Two-road traffic-light controller paced by an upstream free-running mod-8 count.
// Lamps and walk are registered Moore outputs decoded from the next state.

module traffic_ctrl_chk (
   input logic       clk,
   input logic       rst,
   input logic [2:0] main_ryg,
   input logic [2:0] side_ryg,
   input logic       walk,
   input logic [2:0] st
);

   a_lamp_excl: assert property (@(posedge clk) disable iff (!rst)
      (main_ryg == 3'b100) || (side_ryg == 3'b100));

   a_main_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot(main_ryg));

   a_side_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot(side_ryg));

   a_walk_in_sg: assert property (@(posedge clk) disable iff (!rst) walk |-> (st == 3'd2));

   a_st_legal: assert property (@(posedge clk) disable iff (!rst) st <= 3'd4);

endmodule

module traffic_ctrl #(
   parameter int MG_MIN = 2,
   parameter int SG_MAX = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] cnt8,
   input  logic       car_sense,
   input  logic       ped_req,
   output logic [2:0] main_ryg,
   output logic [2:0] side_ryg,
   output logic       walk,
   output logic       tick,
   output logic [2:0] st
);

   typedef enum logic [2:0] {
      MG = 3'd0,
      MY = 3'd1,
      SG = 3'd2,
      SY = 3'd3,
      AR = 3'd4
   } state_e;

   localparam logic [1:0] MG_THR = 2'(MG_MIN - 1);
   localparam logic [1:0] SG_THR = 2'(SG_MAX - 1);

   state_e     state_r;
   state_e     state_nxt_s;
   logic [2:0] cnt_prev_r;
   logic [1:0] tcnt_r;
   logic       req_r;
   logic       ped_r;
   logic       walk_lat_r;
   logic       tick_s;
   logic       enter_sg_s;
   logic       leave_sg_s;
   logic       walk_lat_nxt_s;

   // {main, side} lamp pattern for a state; anything unknown shows all red
   function automatic logic [5:0] lamps(input state_e s);
      logic [5:0] l;
      case (s)
         MG:      l = 6'b001_100;
         MY:      l = 6'b010_100;
         SG:      l = 6'b100_001;
         SY:      l = 6'b100_010;
         AR:      l = 6'b100_100;
         default: l = 6'b100_100;
      endcase
      return l;
   endfunction

   // Only a genuine 7->0 wrap of the upstream count is a tick; stalls and jumps are ignored
   assign tick_s = (cnt_prev_r == 3'd7) && (cnt8 == 3'd0);
   assign tick   = tick_s;
   assign st     = state_r;

   // Next-state decode; all moves wait for a tick except recovery from an illegal encoding
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         MG: begin
            if (tick_s && (tcnt_r >= MG_THR) && req_r) state_nxt_s = MY;
            else                                       state_nxt_s = MG;
         end
         MY: begin
            if (tick_s) state_nxt_s = SG;
            else        state_nxt_s = MY;
         end
         SG: begin
            if (tick_s && ((tcnt_r >= SG_THR) ||
                           ((tcnt_r >= 2'd1) && !car_sense && !ped_r)))
               state_nxt_s = SY;
            else
               state_nxt_s = SG;
         end
         SY: begin
            if (tick_s) state_nxt_s = AR;
            else        state_nxt_s = SY;
         end
         AR: begin
            if (tick_s) state_nxt_s = MG;
            else        state_nxt_s = AR;
         end
         default: state_nxt_s = AR;
      endcase
   end

   // Side-green entry/exit strobes and the walk value captured on entry
   always_comb begin
      enter_sg_s     = 1'b0;
      leave_sg_s     = 1'b0;
      walk_lat_nxt_s = walk_lat_r;
      if (state_nxt_s == SG && state_r != SG) begin
         enter_sg_s     = 1'b1;
         walk_lat_nxt_s = ped_r | ped_req;
      end else if (state_r == SG && state_nxt_s != SG) begin
         leave_sg_s = 1'b1;
      end else begin
         enter_sg_s = 1'b0;
      end
   end

   // State register and Moore lamp/walk registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r  <= MG;
         main_ryg <= 3'b001;
         side_ryg <= 3'b100;
         walk     <= 1'b0;
      end else begin
         state_r              <= state_nxt_s;
         {main_ryg, side_ryg} <= lamps(state_nxt_s);
         walk                 <= (state_nxt_s == SG) && walk_lat_nxt_s;
      end
   end

   // Timebase history and dwell counter (cleared on any state change, saturating at 3)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_prev_r <= 3'd0;
         tcnt_r     <= 2'd0;
      end else begin
         cnt_prev_r <= cnt8;
         if (state_nxt_s != state_r)          tcnt_r <= 2'd0;
         else if (tick_s && tcnt_r != 2'd3)   tcnt_r <= tcnt_r + 2'd1;
         else                                 tcnt_r <= tcnt_r;
      end
   end

   // Request latches; a pedestrian press arriving as SG ends is kept for the next cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req_r      <= 1'b0;
         ped_r      <= 1'b0;
         walk_lat_r <= 1'b0;
      end else begin
         if (enter_sg_s)                 req_r <= 1'b0;
         else if (car_sense || ped_req)  req_r <= 1'b1;
         else                            req_r <= req_r;

         if (ped_req)         ped_r <= 1'b1;
         else if (leave_sg_s) ped_r <= 1'b0;
         else                 ped_r <= ped_r;

         walk_lat_r <= walk_lat_nxt_s;
      end
   end

   traffic_ctrl_chk u_chk (
      .clk      (clk),
      .rst      (rst),
      .main_ryg (main_ryg),
      .side_ryg (side_ryg),
      .walk     (walk),
      .st       (st)
   );

endmodule

// File: tb/tb_traffic_ctrl.sv
// Scoreboard bench for traffic_ctrl: directed scenarios push expected state transitions,
// independent monitors compare transitions, lamps and tick against them.

module tb_traffic_ctrl;

   localparam logic [2:0] S_MG = 3'd0;
   localparam logic [2:0] S_MY = 3'd1;
   localparam logic [2:0] S_SG = 3'd2;
   localparam logic [2:0] S_SY = 3'd3;
   localparam logic [2:0] S_AR = 3'd4;

   typedef struct {
      logic [2:0] st;
      logic [2:0] main_l;
      logic [2:0] side_l;
      logic       w;
      int         t;
   } exp_t;

   logic       clk       = 1'b0;
   logic       rst       = 1'b0;
   logic [2:0] cnt8      = 3'd0;
   logic       car_sense = 1'b0;
   logic       ped_req   = 1'b0;
   logic [2:0] main_ryg;
   logic [2:0] side_ryg;
   logic       walk;
   logic       tick;
   logic [2:0] st;

   exp_t       sb[$];
   exp_t       cur_exp;
   int         n_chk    = 0;
   int         n_pass   = 0;
   int         tick_n   = 0;
   logic       exp_tick = 1'b0;
   logic [2:0] dut_prev = 3'd0;
   logic [2:0] cval     = 3'd0;
   logic [2:0] last_st  = 3'd0;

   traffic_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .cnt8      (cnt8),
      .car_sense (car_sense),
      .ped_req   (ped_req),
      .main_ryg  (main_ryg),
      .side_ryg  (side_ryg),
      .walk      (walk),
      .tick      (tick),
      .st        (st)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, got, want, $time);
   endtask

   function automatic exp_t mk(input logic [2:0] s, input logic w, input int t);
      exp_t e;
      e.st = s;
      e.w  = w;
      e.t  = t;
      case (s)
         S_MG:    begin e.main_l = 3'b001; e.side_l = 3'b100; end
         S_MY:    begin e.main_l = 3'b010; e.side_l = 3'b100; end
         S_SG:    begin e.main_l = 3'b100; e.side_l = 3'b001; end
         S_SY:    begin e.main_l = 3'b100; e.side_l = 3'b010; end
         default: begin e.main_l = 3'b100; e.side_l = 3'b100; end
      endcase
      return e;
   endfunction

   task automatic expect_st(input logic [2:0] s, input logic w, input int t);
      sb.push_back(mk(s, w, t));
   endtask

   // One cycle: new cnt8/rst at the falling edge; predict tick from what the DUT last captured
   task automatic drive(input logic [2:0] v, input logic r);
      @(negedge clk);
      rst      = r;
      exp_tick = (dut_prev == 3'd7) && (v == 3'd0);
      cnt8     = v;
      if (exp_tick) tick_n++;
      dut_prev = r ? v : 3'd0;
   endtask

   task automatic step(input int n);
      repeat (n) begin
         cval = cval + 3'd1;
         drive(cval, 1'b1);
      end
   endtask

   task automatic run_to_tick(input int t);
      for (int i = 0; i < 400 && tick_n < t; i++) step(1);
   endtask

   // Async reset mid-cycle, immediate output check, then release with cnt8 stepping 7->0
   task automatic do_reset();
      @(posedge clk);
      #3;
      rst      = 1'b0;
      dut_prev = 3'd0;
      #1;
      chk("rst_st", st, S_MG);
      chk("rst_main", main_ryg, 3'b001);
      chk("rst_side", side_ryg, 3'b100);
      chk("rst_walk", walk, 1'b0);
      chk("sb_drained", sb.size(), 0);
      sb.delete();
      tick_n = 0;
      drive(3'd7, 1'b0);
      drive(3'd7, 1'b0);
      drive(3'd0, 1'b1);
      cval = 3'd0;
   endtask

   // Transition and lamp monitor
   always @(posedge clk) begin
      #1;
      if (!rst) begin
         last_st = S_MG;
         cur_exp = mk(S_MG, 1'b0, 0);
      end else begin
         if (st !== last_st) begin
            if (sb.size() == 0) begin
               chk("spurious_transition", st, last_st);
            end else begin
               cur_exp = sb.pop_front();
               chk("trans_st", st, cur_exp.st);
               chk("trans_tick", tick_n, cur_exp.t);
            end
            last_st = st;
         end
         chk("main_ryg", main_ryg, cur_exp.main_l);
         chk("side_ryg", side_ryg, cur_exp.side_l);
         chk("walk", walk, cur_exp.w);
      end
   end

   // Tick monitor
   always @(negedge clk) begin
      #1;
      chk("tick", tick, exp_tick);
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();

      // idle: no requests, stays main green
      step(100);
      chk("idle_st", st, S_MG);

      // car held from reset
      do_reset();
      car_sense = 1'b1;
      expect_st(S_MY, 1'b0, 2);
      expect_st(S_SG, 1'b0, 3);
      expect_st(S_SY, 1'b0, 6);
      expect_st(S_AR, 1'b0, 7);
      expect_st(S_MG, 1'b0, 8);
      run_to_tick(8);
      step(4);
      chk("car_sb_empty", sb.size(), 0);
      car_sense = 1'b0;

      // car pulse: early side-green exit
      do_reset();
      car_sense = 1'b1;
      step(1);
      car_sense = 1'b0;
      expect_st(S_MY, 1'b0, 2);
      expect_st(S_SG, 1'b0, 3);
      expect_st(S_SY, 1'b0, 5);
      expect_st(S_AR, 1'b0, 6);
      expect_st(S_MG, 1'b0, 7);
      run_to_tick(7);
      step(4);
      chk("early_sb_empty", sb.size(), 0);

      // pedestrian pulse: walk through full side green
      do_reset();
      ped_req = 1'b1;
      step(1);
      ped_req = 1'b0;
      expect_st(S_MY, 1'b0, 2);
      expect_st(S_SG, 1'b1, 3);
      expect_st(S_SY, 1'b0, 6);
      expect_st(S_AR, 1'b0, 7);
      expect_st(S_MG, 1'b0, 8);
      run_to_tick(8);
      step(4);
      chk("ped_sb_empty", sb.size(), 0);

      // timebase faults with a request pending
      do_reset();
      car_sense = 1'b1;
      run_to_tick(1);
      step(7);
      repeat (20) drive(3'd7, 1'b1);
      drive(3'd5, 1'b1);
      drive(3'd0, 1'b1);
      for (int v = 1; v <= 5; v++) drive(3'(v), 1'b1);
      drive(3'd0, 1'b1);
      chk("fault_st", st, S_MG);
      chk("fault_ticks", tick_n, 1);
      cval = 3'd0;
      expect_st(S_MY, 1'b0, 2);
      run_to_tick(2);
      step(4);
      chk("fault_sb_empty", sb.size(), 0);
      car_sense = 1'b0;

      // reset in side green, then two fresh ticks before leaving MG
      do_reset();
      car_sense = 1'b1;
      step(1);
      car_sense = 1'b0;
      expect_st(S_MY, 1'b0, 2);
      expect_st(S_SG, 1'b0, 3);
      run_to_tick(3);
      step(3);
      chk("pre_rst_st", st, S_SG);
      do_reset();
      car_sense = 1'b1;
      expect_st(S_MY, 1'b0, 2);
      run_to_tick(1);
      step(4);
      chk("post_rst_st", st, S_MG);
      run_to_tick(2);
      step(2);
      chk("post_rst_sb_empty", sb.size(), 0);
      car_sense = 1'b0;
      step(2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
